// File: rtl/alu_pkg.sv
// Shared definitions for the ULA datapath units: default operand width and
// the serial adder's state encoding.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } sa_state_t;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder; the only arithmetic in the bit-serial adder.
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Sum and carry of one bit position.
  always_comb begin
    sum  = x ^ y ^ cin;
    cout = (x & y) | (cin & (x ^ y));
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: operands are latched on start, one sum bit is
// produced per clock from the LSB upwards, and done pulses for one cycle
// when the WIDTH+1-bit result (carry-out in the MSB) is final.
module serial_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   s
);

  // Counter is wide enough to index every bit of s directly.
  localparam int IDX_W = (WIDTH + 1 > 2) ? $clog2(WIDTH + 1) : 1;

  sa_state_t        state, state_n;
  logic [WIDTH-1:0] areg, breg;
  logic [IDX_W-1:0] cnt;
  logic             carry;
  logic             load, shift, last;
  logic             fa_sum, fa_cout;

  assign last = (cnt == IDX_W'(WIDTH - 1));

  full_adder_cell u_fa (
    .x    (areg[0]),
    .y    (breg[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Next-state, status outputs and datapath strobes.
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy  = 1'b1;
        shift = 1'b1;
        if (last) state_n = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        // start here chains straight into the next addition
        if (start) begin
          load    = 1'b1;
          state_n = S_SHIFT;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register, operand shifters, carry flop, bit counter and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      areg  <= '0;
      breg  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        areg  <= a;
        breg  <= b;
        carry <= 1'b0;
        cnt   <= '0;
        s     <= '0;
      end else if (shift) begin
        areg   <= areg >> 1;
        breg   <= breg >> 1;
        carry  <= fa_cout;
        cnt    <= cnt + IDX_W'(1);
        s[cnt] <= fa_sum;
        if (last) s[WIDTH] <= fa_cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed steps plus random operand pairs, all
// checked against plain integer addition and the cycle timing of the
// start/busy/done handshake.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W:0]   s;

  int checks   = 0;
  int failures = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .s     (s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic chk_status(input string tag, input logic exp_busy, input logic exp_done);
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, exp_busy});
    chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
  endtask

  // Issue one addition from IDLE. If glitch is 1..W, a spurious start with
  // a=b=1 is driven during that SHIFT cycle; it must have no effect.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int glitch);
    int exp_sum;
    exp_sum = int'(av) + int'(bv);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    for (int k = 1; k <= W; k++) begin
      chk_status($sformatf("shift%0d", k), 1'b1, 1'b0);
      if (k == glitch) begin
        start = 1'b1; a = W'(1); b = W'(1);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk_status("done_cycle", 1'b0, 1'b1);
    chk("sum", {23'd0, s}, exp_sum);
    @(negedge clk);
    chk_status("idle_after", 1'b0, 1'b0);
    chk("sum_hold", {23'd0, s}, exp_sum);
  endtask

  initial begin
    int seen_done;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;

    // reset and idle
    repeat (2) @(negedge clk);
    chk_status("reset", 1'b0, 1'b0);
    chk("reset_s", {23'd0, s}, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_status("idle", 1'b0, 1'b0);
      chk("idle_s", {23'd0, s}, 0);
    end

    // directed sums, including the extremes
    run_op(8'd100, 8'd55, 0);
    run_op(8'd255, 8'd255, 0);
    run_op(8'd128, 8'd128, 0);
    run_op(8'd0, 8'd0, 0);

    // start during SHIFT is ignored; exactly one done pulse
    run_op(8'd10, 8'd20, 3);
    seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    chk("single_done", seen_done, 0);

    // back-to-back with start held high
    a = 8'd7; b = 8'd9; start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= W; k++) begin
      chk_status("b2b_shift", 1'b1, 1'b0);
      @(negedge clk);
    end
    chk_status("b2b_done1", 1'b0, 1'b1);
    chk("b2b_sum1", {23'd0, s}, 16);
    a = 8'd200; b = 8'd100;
    @(negedge clk);
    start = 1'b0;
    chk_status("b2b_restart", 1'b1, 1'b0);
    chk("b2b_cleared", {23'd0, s[0]}, 0);
    for (int k = 2; k <= W; k++) begin
      @(negedge clk);
      chk_status("b2b_shift2", 1'b1, 1'b0);
    end
    @(negedge clk);
    chk_status("b2b_done2", 1'b0, 1'b1);
    chk("b2b_sum2", {23'd0, s}, 300);
    @(negedge clk);

    // reset mid-operation aborts with no done pulse
    a = 8'd60; b = 8'd70; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 4; k++) @(negedge clk);
    chk_status("abort_pre", 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_status("abort", 1'b0, 1'b0);
    chk("abort_s", {23'd0, s}, 0);
    seen_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    chk("abort_quiet", seen_done, 0);
    run_op(8'd60, 8'd70, 0);

    // random operand pairs against integer addition
    for (int n = 0; n < 12; n++) begin
      run_op(W'($urandom), W'($urandom), (n % 3 == 0) ? int'($urandom_range(1, W)) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
